// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: SCIC fetch stage with PC ownership, IR latch and valid/ready issue.
// Optional ILLEGAL_OPCODE_TRAP_EN replaces opcodes A..F with a NOP and flags instr_illegal.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int RESET_PC = 0
)(
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_chip_select,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [3:0]            instr_opcode,
    output logic [15:0]           instr_operand,
    output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef ILLEGAL_OPCODE_TRAP_EN
   ,output logic                  instr_illegal
`endif
);
    localparam logic [ADDR_WIDTH-1:0] RPC = ADDR_WIDTH'(RESET_PC);
    typedef enum logic {FETCH, ISSUE} state_t;
    state_t state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic [DATA_WIDTH-1:0] ir;
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end
    always_comb begin
        rom_chip_select = !reset && state == FETCH;
        instr_valid     = !reset && state == ISSUE;
        state_next      = state == FETCH ? ISSUE : (instr_ready ? FETCH : ISSUE);
        pc_next         = ir[DATA_WIDTH-1 -: 4] == 4'h8 ? ir[ADDR_WIDTH-1:0] : pc + 1'b1;
    end
    // IR and instr_pc only load in FETCH, so they stay stable under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RPC;
            ir       <= '0;
            instr_pc <= '0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            instr_illegal <= 1'b0;
`endif
        end else if (state == FETCH) begin
            instr_pc <= pc;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            instr_illegal <= rom_data[DATA_WIDTH-1 -: 4] >= 4'hA;
            ir <= rom_data[DATA_WIDTH-1 -: 4] >= 4'hA ? '0 : rom_data;
`else
            ir <= rom_data;
`endif
        end else if (instr_ready) begin
            pc <= pc_next;
        end
    end
    assign rom_address   = pc;
    assign instr_opcode  = ir[DATA_WIDTH-1 -: 4];
    assign instr_operand = ir[15:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random ROM/backpressure stimulus; expected instruction stream
// is derived by walking the ROM image and checked by an independent monitor.
module tb_instr_fetch_unit;
    logic        clk = 0, reset = 1, instr_ready = 0;
    logic [4:0]  rom_address, instr_pc;
    logic        rom_chip_select, instr_valid;
    logic [31:0] rom_data;
    logic [3:0]  instr_opcode;
    logic [15:0] instr_operand;
    logic [31:0] rom [32];
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic instr_illegal;
`endif
    int total = 0, passes = 0;
    typedef struct {logic [3:0] op; logic [15:0] opd; logic [4:0] pc; logic ill;} exp_t;
    exp_t q[$];
    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .rom_address(rom_address), .rom_chip_select(rom_chip_select),
        .rom_data(rom_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_operand(instr_operand), .instr_pc(instr_pc)
`ifdef ILLEGAL_OPCODE_TRAP_EN
       ,.instr_illegal(instr_illegal)
`endif
    );
    assign rom_data = rom[rom_address];
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passes++;
        else $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    endtask
    // Walk the program from address 0 the way the CPU would execute it
    function automatic void gen();
        logic [4:0] p = 0;
        logic [31:0] w;
        exp_t e;
        q.delete();
        repeat (200) begin
            w = rom[p];
            e.pc = p; e.op = w[31:28]; e.opd = w[15:0]; e.ill = 0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            if (w[31:28] >= 4'hA) begin e.op = 0; e.opd = 0; e.ill = 1; end
`endif
            q.push_back(e);
            p = e.op == 4'h8 ? e.opd[4:0] : p + 5'd1;
        end
    endfunction
    // Monitor: samples at negedge, pops one expected entry per handshake
    logic ev = 0;
    always @(negedge clk) begin
        if (reset) begin
            chk("valid_in_reset", {31'd0, instr_valid}, 0);
            chk("cs_in_reset", {31'd0, rom_chip_select}, 0);
            ev = 0;
        end else if (q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            chk("valid_sequence", {31'd0, instr_valid}, {31'd0, ev});
            chk("rom_address", {27'd0, rom_address}, {27'd0, q[0].pc});
            chk("cs", {31'd0, rom_chip_select}, {31'd0, !instr_valid});
            if (instr_valid) begin
                chk("opcode", {28'd0, instr_opcode}, {28'd0, q[0].op});
                chk("operand", {16'd0, instr_operand}, {16'd0, q[0].opd});
                chk("instr_pc", {27'd0, instr_pc}, {27'd0, q[0].pc});
`ifdef ILLEGAL_OPCODE_TRAP_EN
                chk("illegal", {31'd0, instr_illegal}, {31'd0, q[0].ill});
`endif
                if (instr_ready) begin void'(q.pop_front()); ev = 0; end
                else ev = 1;
            end else ev = 1;
        end
    end
    task automatic step(input logic rdy);
        @(posedge clk); #2 instr_ready = rdy;
    endtask
    initial begin
        int n;
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        rom[0] = 32'h4000_000F; rom[1] = 32'h7000_005F; rom[5] = 32'h8000_FFE3;
        rom[22] = 32'h8000_0000; rom[31] = 32'h0000_0000; rom[3] = 32'hC000_1234;
        gen();
        repeat (2) step(1);
        reset = 0;
        repeat (20) step(1);
        repeat (300) step(1'($urandom_range(0, 1)));
        step(0); reset = 1;
        for (int i = 0; i < 32; i++) begin
            rom[i] = $urandom;
            if (rom[i][31:28] == 4'h8) rom[i][31:28] = 4'h9;
        end
        gen();
        step(0); reset = 0;
        repeat (100) step(1);
        repeat (30) step(1'($urandom_range(0, 1)));
        n = 0;
        while (!instr_valid && n < 10) begin step(0); n++; end
        chk("mid_reset_reach_issue", {31'd0, instr_valid}, 1);
        instr_ready = 1; reset = 1;
        gen();
        step(1); reset = 0;
        repeat (30) step(1'($urandom_range(0, 1)));
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the SCIC CPU, sitting between the program ROM and the execute/control stage.
- Owns the program counter and drives the ROM address/chip-select.
- Latches the 32-bit instruction word and splits it into opcode and operand.
- Presents the instruction to execute with a valid/ready handshake.
- Resolves BR (opcode 8) locally by redirecting the PC.

Parameters:
ADDR_WIDTH, 5, ROM address / PC width
DATA_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
rom_address  output  ADDR_WIDTH  address to ROM, equal to the PC
rom_chip_select  output  1  ROM enable; high only in FETCH
rom_data  input  DATA_WIDTH  ROM read data; combinational from rom_address
instr_valid  output  1  decoded instruction available to execute
instr_ready  input  1  execute accepts the instruction this cycle
instr_opcode  output  4  IR[31:28]
instr_operand  output  16  IR[15:0]
instr_pc  output  ADDR_WIDTH  address the current IR was fetched from

Behaviour:
Interface:
- One clock, clk. Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of clk.

Reset (reset high at a clock edge):
- pc <= RESET_PC; IR <= 0; instr_pc <= 0; state <= FETCH.
- While reset is high: instr_valid=0, rom_chip_select=0.
- Reset wins over every other event, including a handshake in the same cycle.

State machine (2 states):
- FETCH: rom_address=pc, rom_chip_select=1, instr_valid=0. At the clock edge: IR <= rom_data, instr_pc <= pc, state -> ISSUE. Unconditional; execute is never waited on here.
- ISSUE: rom_chip_select=0, rom_address holds pc, instr_valid=1.
  - instr_opcode, instr_operand and instr_pc are driven from the registers and stay stable while instr_ready=0.
  - Handshake (instr_valid & instr_ready at an edge): pc <= next_pc, state -> FETCH.
  - No handshake: hold everything.

next_pc:
- IR opcode == 4'h8 (BR): IR[ADDR_WIDTH-1:0]. Upper operand bits are ignored.
- Otherwise pc + 1, modulo 2^ADDR_WIDTH (31 wraps to 0).

Other rules:
- Opcode 0 (NOP) is issued like any other instruction; execute ignores it.
- Bits [27:16] are discarded.
- Latency: reset release to first instr_valid = 1 cycle (one FETCH cycle).
- Throughput: 1 instruction per 2 cycles when instr_ready is held high.
- instr_ready is ignored in FETCH.
- Decode outputs are purely registered; there is no combinational path from rom_data to any output.

Optional Feature:
Macro: ILLEGAL_OPCODE_TRAP_EN.
Defined:
- Adds output port instr_illegal (1 bit, registered, reset 0).
- In FETCH, if rom_data[31:28] is in 4'hA..4'hF: IR <= 32'h0000_0000 (NOP) and instr_illegal <= 1. Otherwise instr_illegal <= 0.
- instr_pc still records the faulting address.
- instr_illegal is meaningful only while instr_valid=1 and holds with the IR.
Undefined:
- No instr_illegal port.
- All opcodes pass through unmodified; 4'hA..4'hF are issued as-is and PC advances by 1.

Test Plan:
1. Reset high 2 cycles, then low; ROM[0]=4000_000F; instr_ready=1 -> cycle 1: cs=1, addr=0; cycle 2: valid=1, opcode=4, operand=000F, instr_pc=0; cycle 3: cs=1, addr=1.
2. Backpressure: ROM[1]=7000_005F; hold instr_ready=0 for 5 cycles in ISSUE -> valid stays 1, opcode=7, operand=005F, rom_address=1, cs=0 throughout. Raise instr_ready -> next cycle FETCH at addr 2.
3. Branch: ROM[16h]=8000_0000 accepted -> next FETCH at addr 0. Also ROM[5]=8000_FFE3 -> next FETCH at addr 03 (upper bits ignored).
4. Wrap: PC=31 with ROM[31]=0000_0000 (NOP) accepted -> next FETCH at addr 0, instr_pc=31 for the NOP.
5. Reset mid-operation: assert reset during ISSUE with instr_ready=1 -> next cycle valid=0, pc=RESET_PC; no increment from the coincident handshake.
6. With ILLEGAL_OPCODE_TRAP_EN: ROM[3]=C000_1234 -> valid=1, opcode=0, operand=0000, instr_illegal=1, instr_pc=3; next fetch addr 4. Without the macro -> opcode=C, operand=1234.
